// File: rtl/row_source_scheduler.sv
// Per-request row source scheduler for the OLED byte-fetch port: maps the pixel
// address to a text row, selects its source, runs text through the font ROM.
module row_source_scheduler #(
    parameter int                 NUM_SRC      = 4,
    parameter int                 SEL_W        = 2,
    parameter logic [NUM_SRC-1:0] GRAPHIC_MASK = 4'b1000,
    parameter logic [7:0]         BLANK_BYTE   = 8'h00
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 pixelReq_i,
    input  logic [9:0]           pixelAddress_i,
    output logic [7:0]           pixelData_o,
    output logic                 pixelValid_o,
    output logic                 busy_o,
    output logic [3:0]           charIndex_o,
    output logic [9:0]           srcAddress_o,
    input  logic [8*NUM_SRC-1:0] srcBytes_i,
    output logic [11:0]          fontAddr_o,
    input  logic [7:0]           fontData_i,
    input  logic                 cfgWe_i,
    input  logic [4*SEL_W-1:0]   cfgMap_i,
    input  logic [3:0]           cfgEnable_i,
    output logic [2:0]           fsm_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SRC_WAIT  = 3'd1,
        LOOKUP    = 3'd2,
        FONT_WAIT = 3'd3,
        OUTPUT    = 3'd4
    } state_t;

    function automatic logic [4*SEL_W-1:0] identity_map();
        logic [4*SEL_W-1:0] m;
        m = '0;
        for (int r = 0; r < 4; r++) m[SEL_W*r +: SEL_W] = SEL_W'(r);
        return m;
    endfunction

    localparam logic [4*SEL_W-1:0] IDENTITY_MAP = identity_map();

    state_t             state;
    state_t             state_next;
    logic [9:0]         addr_q;
    logic [11:0]        font_addr_q;
    logic [7:0]         res_q;
    logic               text_q;
    logic [7:0]         pixel_data;
    logic [4*SEL_W-1:0] active_map;
    logic [3:0]         active_en;
    logic [4*SEL_W-1:0] pend_map;
    logic [3:0]         pend_en;
    logic               pending;

    logic               accept;
    logic               frame_start;
    logic [1:0]         row;
    logic [SEL_W-1:0]   sel;
    logic [7:0]         sel_byte;
    logic               sel_ok;
    logic               sel_graphic;
    logic [7:0]         char_code;
    logic               lookup_text;
    logic [11:0]        font_addr_new;

    // Handshake: pixelReq_i is taken only in IDLE; exactly one pixelValid_o
    // pulse follows each taken request, and requests seen while busy are dropped.
    assign accept      = (state == IDLE) && pixelReq_i;
    assign frame_start = accept && (pixelAddress_i == '0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (pixelReq_i) state_next = SRC_WAIT;
            SRC_WAIT:  state_next = LOOKUP;
            LOOKUP:    state_next = FONT_WAIT;
            FONT_WAIT: state_next = OUTPUT;
            OUTPUT:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        row         = addr_q[9:8];
        sel         = active_map[SEL_W*int'(row) +: SEL_W];
        sel_byte    = BLANK_BYTE;
        sel_ok      = 1'b0;
        sel_graphic = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (int'(sel) == s) begin
                sel_ok      = active_en[row];
                sel_byte    = srcBytes_i[8*s +: 8];
                sel_graphic = GRAPHIC_MASK[s];
            end
        end
        // Non-printable codes render as a space rather than garbage glyphs.
        char_code     = (sel_byte < 8'h20 || sel_byte > 8'h7E) ? 8'h20 : sel_byte;
        lookup_text   = sel_ok && !sel_graphic;
        font_addr_new = {char_code, addr_q[7], addr_q[2:0]};
    end

    // The ROM must see the address during LOOKUP so its data lands in FONT_WAIT.
    assign fontAddr_o   = (state == LOOKUP && lookup_text) ? font_addr_new : font_addr_q;
    assign charIndex_o  = addr_q[6:3];
    assign srcAddress_o = addr_q;
    assign pixelData_o  = pixel_data;
    assign pixelValid_o = (state == OUTPUT);
    assign busy_o       = (state != IDLE);
    assign fsm_state    = state;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state       <= IDLE;
            addr_q      <= '0;
            font_addr_q <= '0;
            res_q       <= '0;
            text_q      <= 1'b0;
            pixel_data  <= '0;
            active_map  <= IDENTITY_MAP;
            active_en   <= '1;
            pend_map    <= '0;
            pend_en     <= '0;
            pending     <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) addr_q <= pixelAddress_i;
            if (state == LOOKUP) begin
                text_q <= lookup_text;
                res_q  <= sel_ok ? sel_byte : BLANK_BYTE;
                if (lookup_text) font_addr_q <= font_addr_new;
            end
            if (state == FONT_WAIT) pixel_data <= text_q ? fontData_i : res_q;
            // Map swaps only at frame start so a frame never mixes layouts.
            if (frame_start && pending) begin
                active_map <= pend_map;
                active_en  <= pend_en;
            end
            if (cfgWe_i) begin
                pend_map <= cfgMap_i;
                pend_en  <= cfgEnable_i;
                pending  <= 1'b1;
            end else if (frame_start) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_row_source_scheduler.sv
// Directed bench for row_source_scheduler: transaction-level model plus
// per-cycle compare and hand-computed literal expectations.
module tb_row_source_scheduler;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        pixelReq_i;
    logic [9:0]  pixelAddress_i;
    logic [7:0]  pixelData_o;
    logic        pixelValid_o;
    logic        busy_o;
    logic [3:0]  charIndex_o;
    logic [9:0]  srcAddress_o;
    logic [31:0] srcBytes_i = '0;
    logic [11:0] fontAddr_o;
    logic [7:0]  fontData_i = '0;
    logic        cfgWe_i;
    logic [7:0]  cfgMap_i;
    logic [3:0]  cfgEnable_i;
    logic [2:0]  fsm_state;

    row_source_scheduler dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .pixelReq_i(pixelReq_i), .pixelAddress_i(pixelAddress_i),
        .pixelData_o(pixelData_o), .pixelValid_o(pixelValid_o), .busy_o(busy_o),
        .charIndex_o(charIndex_o), .srcAddress_o(srcAddress_o),
        .srcBytes_i(srcBytes_i), .fontAddr_o(fontAddr_o), .fontData_i(fontData_i),
        .cfgWe_i(cfgWe_i), .cfgMap_i(cfgMap_i), .cfgEnable_i(cfgEnable_i),
        .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- sources and font ROM (registered, 1-cycle) ----------------
    logic [7:0] src_table [4];

    function automatic logic [7:0] font_rom(input logic [11:0] a);
        if (a == 12'h480) return 8'h7F;
        return a[7:0] ^ a[11:4];
    endfunction

    always @(posedge clk_i) begin
        srcBytes_i <= {src_table[3], src_table[2], src_table[1], src_table[0]};
        fontData_i <= font_rom(fontAddr_o);
    end

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    int          cyc = 0;
    int          m_acc = -100;
    logic [7:0]  m_map = 8'hE4;
    logic [3:0]  m_en = 4'hF;
    logic [7:0]  m_pmap = 8'h00;
    logic [3:0]  m_pen = 4'h0;
    bit          m_pend = 0;
    logic [9:0]  m_addr = '0;
    bit          m_txt = 0;
    logic [11:0] m_fa_new = '0;
    logic [11:0] m_fa_held = '0;
    logic [7:0]  m_hold = '0;
    logic [7:0]  exp_q [$];

    task automatic model_reset();
        m_acc = -100; m_map = 8'hE4; m_en = 4'hF; m_pend = 0;
        m_addr = '0; m_txt = 0; m_fa_new = '0; m_fa_held = '0; m_hold = '0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [9:0] addr);
        int row, sel;
        logic [7:0] ch, d;
        logic [11:0] fa;
        if (m_txt) m_fa_held = m_fa_new;
        if (addr == 10'd0) begin
            if (m_pend) begin m_map = m_pmap; m_en = m_pen; end
            m_pend = 0;
        end
        row = int'(addr[9:8]);
        sel = int'((m_map >> (2*row)) & 8'd3);
        m_txt = 0;
        if (!m_en[row]) d = 8'h00;
        else if (sel == 3) d = src_table[sel];
        else begin
            ch = src_table[sel];
            if (ch < 8'h20 || ch > 8'h7E) ch = 8'h20;
            fa = {ch, addr[7], addr[2:0]};
            d = font_rom(fa);
            m_txt = 1;
            m_fa_new = fa;
        end
        m_addr = addr;
        m_acc = cyc;
        exp_q.push_back(d);
    endtask

    always @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) model_reset();
        else begin
            cyc++;
            if (pixelReq_i && cyc >= m_acc + 5) model_accept(pixelAddress_i);
            if (cfgWe_i) begin m_pmap = cfgMap_i; m_pen = cfgEnable_i; m_pend = 1; end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_i) begin
        logic exp_valid, exp_busy;
        exp_valid = reset_ni && (cyc == m_acc + 3);
        exp_busy  = reset_ni && (cyc >= m_acc) && (cyc <= m_acc + 3);
        if (exp_valid && exp_q.size() > 0) m_hold = exp_q.pop_front();
        check("valid", 32'(pixelValid_o), 32'(exp_valid));
        check("busy", 32'(busy_o), 32'(exp_busy));
        check("pixel_data", 32'(pixelData_o), 32'(m_hold));
        check("char_index", 32'(charIndex_o), 32'(m_addr[6:3]));
        check("src_address", 32'(srcAddress_o), 32'(m_addr));
        check("font_addr", 32'(fontAddr_o),
              32'((m_txt && cyc >= m_acc + 1) ? m_fa_new : m_fa_held));
    end

    // ---------------- driver tasks ----------------
    task automatic do_req(input logic [9:0] addr, input logic we, input logic [7:0] map,
                          input logic [3:0] en, input logic [7:0] exp_data,
                          input logic [11:0] exp_fa);
        int start;
        bit seen;
        @(posedge clk_i); #1;
        pixelReq_i = 1'b1; pixelAddress_i = addr;
        cfgWe_i = we; cfgMap_i = map; cfgEnable_i = en;
        start = cyc;
        @(posedge clk_i); #1;
        pixelReq_i = 1'b0; cfgWe_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk_i);
            if (pixelValid_o) begin
                seen = 1;
                check("lit_latency", 32'(cyc - start), 32'd4);
                check("lit_data", 32'(pixelData_o), 32'(exp_data));
                check("lit_font_addr", 32'(fontAddr_o), 32'(exp_fa));
            end
        end
        check("lit_strobe_seen", 32'(seen), 32'd1);
    endtask

    task automatic req(input logic [9:0] addr, input logic [7:0] exp_data,
                       input logic [11:0] exp_fa);
        do_req(addr, 1'b0, 8'h00, 4'h0, exp_data, exp_fa);
    endtask

    task automatic cfg_write(input logic [7:0] map, input logic [3:0] en);
        @(posedge clk_i); #1;
        cfgWe_i = 1'b1; cfgMap_i = map; cfgEnable_i = en;
        @(posedge clk_i); #1;
        cfgWe_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int strobes, first_cyc, second_cyc, k;
        reset_ni = 1'b0; pixelReq_i = 1'b0; pixelAddress_i = '0;
        cfgWe_i = 1'b0; cfgMap_i = '0; cfgEnable_i = '0;
        src_table[0] = 8'h48; src_table[1] = 8'h41; src_table[2] = 8'h31; src_table[3] = 8'h0F;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid", 32'(pixelValid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_data", 32'(pixelData_o), 32'd0);
        check("rst_char_index", 32'(charIndex_o), 32'd0);
        check("rst_src_address", 32'(srcAddress_o), 32'd0);
        check("rst_font_addr", 32'(fontAddr_o), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        reset_ni = 1'b1;

        // Text row 0 ('H'), then graphic row 3.
        req(10'h000, 8'h7F, 12'h480);
        req(10'h385, 8'h0F, 12'h480);
        check("lit_src_address", 32'(srcAddress_o), 32'h385);

        // Mid-frame config stays pending until the next frame start.
        cfg_write(8'hE6, 4'hF);
        req(10'h010, 8'h7F, 12'h480);
        check("lit_char_index", 32'(charIndex_o), 32'd2);
        req(10'h000, 8'h21, 12'h310);

        // Disabled row returns blank; re-enabled control char becomes a space.
        cfg_write(8'hE4, 4'b1101);
        req(10'h000, 8'h7F, 12'h480);
        req(10'h140, 8'h00, 12'h480);
        src_table[1] = 8'h07;
        cfg_write(8'hE4, 4'hF);
        req(10'h000, 8'h7F, 12'h480);
        req(10'h140, 8'h20, 12'h200);
        req(10'h1C5, 8'h2D, 12'h20D);
        check("lit_char_index_bot", 32'(charIndex_o), 32'd8);
        src_table[1] = 8'h7F;
        req(10'h140, 8'h20, 12'h200);
        src_table[0] = 8'h7E;
        req(10'h010, 8'h9E, 12'h7E0);

        // Write coinciding with frame start: old pending applies, new one waits.
        src_table[1] = 8'h41;
        cfg_write(8'hE5, 4'hF);
        do_req(10'h000, 1'b1, 8'hE7, 4'hF, 8'h51, 12'h410);
        req(10'h000, 8'h0F, 12'h410);

        // Back-to-back requests for 10 cycles.
        strobes = 0; first_cyc = 0; second_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i); #1;
            pixelReq_i = (i < 10); pixelAddress_i = 10'h205;
            @(negedge clk_i);
            if (pixelValid_o) begin
                strobes++;
                if (strobes == 1) first_cyc = cyc;
                if (strobes == 2) second_cyc = cyc;
                check("lit_b2b_data", 32'(pixelData_o), 32'h24);
            end
        end
        check("lit_b2b_strobes", 32'(strobes), 32'd2);
        check("lit_b2b_spacing", 32'(second_cyc - first_cyc), 32'd5);

        // Reset during FONT_WAIT drops the request and restores identity map.
        @(posedge clk_i); #1;
        pixelReq_i = 1'b1; pixelAddress_i = 10'h010;
        @(posedge clk_i); #1;
        pixelReq_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("lit_in_font_wait", 32'(fsm_state), 32'd3);
        reset_ni = 1'b0;
        #1;
        check("lit_rst_busy", 32'(busy_o), 32'd0);
        check("lit_rst_valid", 32'(pixelValid_o), 32'd0);
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            if (pixelValid_o) strobes++;
        end
        @(posedge clk_i); #1;
        reset_ni = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (pixelValid_o) strobes++;
        end
        check("lit_rst_no_strobe", 32'(strobes), 32'd0);
        req(10'h010, 8'h9E, 12'h7E0);

        k = 0;
        repeat (3) @(posedge clk_i);
        k = exp_q.size();
        check("lit_queue_drained", 32'(k), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
